// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core.
// Sequences the shared ALU through fetch, decode, address calculation,
// execute and writeback, and strobes the PC, IR, memory and register file.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [1:0] pcsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   pcwrite;
  logic   branch;

  assign state = state_q;

  // State register; reset returns to FETCH immediately, aborting any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode; strobes are masked while reset is high.
  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 3'b000;
    pcsrc      = 2'b00;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluop   = 3'b010;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = 3'b010;
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXEC;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEX;
        else if (op == OP_J)            state_d = S_JUMP;
        else                            illegal_op = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 3'b010;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        state_d = S_ALUWB;
        case (funct)
          6'b100000: aluop = 3'b010;
          6'b100010: aluop = 3'b110;
          6'b100100: aluop = 3'b000;
          6'b100101: aluop = 3'b001;
          6'b101010: aluop = 3'b111;
          default: begin
            // Unsupported function: flag it and skip writeback.
            aluop      = 3'b010;
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 3'b110;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 3'b010;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    pc_en = pcwrite | (branch & zero);

    if (reset) begin
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a per-instruction path model checked on
// every cycle, plus literal state sequences and strobe counts per instruction.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op_i = LW;
  logic [5:0] funct_i = 6'b000000;
  logic       zero_i = 1'b0;
  logic       iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg;
  logic       pc_en, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int m_step = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op_i), .funct(funct_i), .zero(zero_i),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic int alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 2;
    endcase
  endfunction

  // Cycles per instruction, FETCH through last state.
  function automatic int plen(input logic [5:0] o, input logic [5:0] f);
    case (o)
      LW:        return 5;
      SW, ADDI:  return 4;
      RT:        return funct_ok(f) ? 4 : 3;
      BEQ, JMP:  return 3;
      default:   return 2;
    endcase
  endfunction

  // State visited at step k of an instruction.
  function automatic int state_at(input logic [5:0] o, input int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    case (o)
      LW:      return (k == 2) ? 2 : (k == 3) ? 3 : 4;
      SW:      return (k == 2) ? 2 : 5;
      RT:      return (k == 2) ? 6 : 7;
      ADDI:    return (k == 2) ? 9 : 10;
      BEQ:     return 8;
      JMP:     return 11;
      default: return 0;
    endcase
  endfunction

  // Model: position within the current instruction.
  always @(posedge clk or posedge reset) begin
    if (reset) m_step <= 0;
    else       m_step <= (m_step + 1 >= plen(op_i, funct_i)) ? 0 : m_step + 1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int s;
    bit r;
    #2;
    r = reset;
    s = r ? 0 : state_at(op_i, m_step);
    chk("state", state, s);
    chk("iord", iord, (s == 3 || s == 5));
    chk("alusrca", alusrca, (s == 2 || s == 6 || s == 8 || s == 9));
    chk("alusrcb", alusrcb, (s == 0) ? 1 : (s == 1) ? 3 : (s == 2 || s == 9) ? 2 : 0);
    chk("aluop", aluop, (s == 6) ? alu_of_funct(funct_i) : (s == 8) ? 6 :
                        (s <= 2 || s == 9) ? 2 : 0);
    chk("pcsrc", pcsrc, (s == 8) ? 1 : (s == 11) ? 2 : 0);
    chk("irwrite", irwrite, !r && s == 0);
    chk("memwrite", memwrite, !r && s == 5);
    chk("regwrite", regwrite, !r && (s == 4 || s == 7 || s == 10));
    chk("regdst", regdst, (s == 7));
    chk("memtoreg", memtoreg, (s == 4));
    chk("pc_en", pc_en, !r && (s == 0 || s == 11 || (s == 8 && zero_i)));
    chk("illegal_op", illegal_op, !r && ((s == 1 && plen(op_i, funct_i) == 2) ||
                                         (s == 6 && !funct_ok(funct_i))));
  end

  // Run one instruction from FETCH; seq holds expected states as nibbles, first in MSB.
  task automatic run(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int n, input logic [19:0] seq,
                     input int alu2, input int rw, input int mw, input int pe,
                     input int ill);
    int c_rw = 0, c_mw = 0, c_pe = 0, c_ill = 0, a2 = -1;
    op_i = o; funct_i = f; zero_i = z;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({name, "_seq"}, state, int'(seq[4*(4-i) +: 4]));
      if (i == 2) a2 = aluop;
      c_rw += regwrite; c_mw += memwrite; c_pe += pc_en; c_ill += illegal_op;
      @(negedge clk);
    end
    if (n > 2) chk({name, "_aluop"}, a2, alu2);
    chk({name, "_regwrite_cnt"}, c_rw, rw);
    chk({name, "_memwrite_cnt"}, c_mw, mw);
    chk({name, "_pc_en_cnt"}, c_pe, pe);
    chk({name, "_illegal_cnt"}, c_ill, ill);
    $display("instr %s op=%b funct=%b zero=%0b cycles=%0d", name, o, f, z, n);
  endtask

  // Abort an instruction with reset after k cycles, then release it.
  task automatic abort(input string name, input logic [5:0] o, input int k,
                       input int st);
    op_i = o; funct_i = 6'b0;
    repeat (k) @(negedge clk);
    #1;
    chk({name, "_pre_state"}, state, st);
    chk({name, "_pre_strobe"}, int'(regwrite | memwrite), 1);
    reset = 1'b1;
    #1;
    chk({name, "_rst_state"}, state, 0);
    chk({name, "_rst_strobe"}, int'(regwrite | memwrite), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({name, "_restart_state"}, state, 0);
    chk({name, "_restart_irwrite"}, irwrite, 1);
    $display("abort %s in state %0d", name, st);
  endtask

  initial begin
    #1;
    chk("reset_state", state, 0);
    chk("reset_irwrite", irwrite, 0);
    chk("reset_pc_en", pc_en, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run("lw",   LW,   6'b000000, 1'b0, 5, 20'h01234, 2, 1, 0, 1, 0);
    run("slt",  RT,   6'b101010, 1'b0, 4, 20'h01670, 7, 1, 0, 1, 0);
    run("add",  RT,   6'b100000, 1'b0, 4, 20'h01670, 2, 1, 0, 1, 0);
    run("sub",  RT,   6'b100010, 1'b1, 4, 20'h01670, 6, 1, 0, 1, 0);
    run("and",  RT,   6'b100100, 1'b0, 4, 20'h01670, 0, 1, 0, 1, 0);
    run("or",   RT,   6'b100101, 1'b0, 4, 20'h01670, 1, 1, 0, 1, 0);
    run("beq1", BEQ,  6'b000000, 1'b1, 3, 20'h01800, 6, 0, 0, 2, 0);
    run("beq0", BEQ,  6'b000000, 1'b0, 3, 20'h01800, 6, 0, 0, 1, 0);
    run("sw",   SW,   6'b000000, 1'b0, 4, 20'h01250, 2, 0, 1, 1, 0);
    run("j",    JMP,  6'b000000, 1'b0, 3, 20'h01B00, 0, 0, 0, 2, 0);
    run("addi", ADDI, 6'b000000, 1'b0, 4, 20'h019A0, 2, 1, 0, 1, 0);
    run("badop", 6'b111111, 6'b000000, 1'b0, 2, 20'h01000, 0, 0, 0, 1, 1);
    run("badfn", RT,  6'b000000, 1'b0, 3, 20'h01600, 2, 0, 0, 1, 1);
    abort("lw_abort", LW, 4, 4);
    run("lw2",  LW,   6'b000000, 1'b0, 5, 20'h01234, 2, 1, 0, 1, 0);
    abort("sw_abort", SW, 3, 5);
    run("add2", RT,   6'b100000, 1'b0, 4, 20'h01670, 2, 1, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
